// File: rtl/if_id_buffer.sv
// if_id_buffer: 2-entry fetch-to-decode FIFO with flush and NOP insertion.
// Define IFID_BUBBLE_CNT_EN to add the saturating bubble_cnt output.
module if_id_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PCInc_in,
  input  logic [15:0] Instr_in,
  input  logic        nop_in,
  input  logic        err_in,
  input  logic        Flush,
  input  logic        Stall_ID,
  input  logic        Dmem_Stall,
  output logic        En,
  output logic        Valid_out,
  output logic [15:0] PCInc_out,
  output logic [15:0] Instr_out,
`ifdef IFID_BUBBLE_CNT_EN
  output logic [15:0] bubble_cnt,
`endif
  output logic        err_out
);
  logic [15:0] pc_q    [DEPTH];
  logic [15:0] instr_q [DEPTH];
  logic        err_q   [DEPTH];
  logic        wp, rp;
  logic [1:0]  count;
  logic        full, ready, push, pop;

  always_comb begin
    full      = count == 2'd2;
    ready     = ~Stall_ID & ~Dmem_Stall;
    push      = ~nop_in & ~full & ~Flush;
    pop       = (count != 2'd0) & ready & ~Flush;
    En        = ~full;
    Valid_out = count != 2'd0;
    PCInc_out = Valid_out ? pc_q[rp] : 16'h0000;
    Instr_out = Valid_out ? instr_q[rp] : NOP_INSTR;
    err_out   = Valid_out & err_q[rp];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= 2'd0;
      wp    <= 1'b0;
      rp    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= 16'h0000;
        instr_q[i] <= 16'h0000;
        err_q[i]   <= 1'b0;
      end
    end else if (Flush) begin
      count <= 2'd0;
      wp    <= 1'b0;
      rp    <= 1'b0;
    end else begin
      if (push) begin
        pc_q[wp]    <= PCInc_in;
        instr_q[wp] <= Instr_in;
        err_q[wp]   <= err_in;
        wp          <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(pop);
    end
  end

`ifdef IFID_BUBBLE_CNT_EN
  // Counts decode-idle cycles; Flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst) bubble_cnt <= 16'h0000;
    else if (ready && count == 2'd0 && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
  end
`endif
endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Fetch-to-decode boundary stage. Accepts one instruction per cycle from the fetch stage and holds it in a 2-entry FIFO.
- Presents the oldest entry to decode. Back-pressures fetch through its En input.
- Flushes on a taken branch or jump, and turns fetch bubbles and empty states into architectural NOPs.
- Absorbs the one-cycle gap between the decode hazard stall and the registered fetch enable, so no fetched instruction is lost.

Parameters:
- DEPTH, 2, FIFO entries; only 2 is supported (pointer width 1, count width 2).
- NOP_INSTR, 16'h0800, encoding driven on Instr_out when no valid entry is present.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- PCInc_in  input  16  PC+2 from fetch.
- Instr_in  input  16  instruction from fetch.
- nop_in  input  1  fetch bubble; entry is not valid when 1.
- err_in  input  1  fetch memory error for this instruction.
- Flush  input  1  taken branch/jump from downstream; discard all held and incoming entries.
- Stall_ID  input  1  decode hazard stall; head must not be consumed.
- Dmem_Stall  input  1  data-memory stall; head must not be consumed.
- En  output  1  to fetch En; 1 when FIFO is not full (registered-state derived).
- Valid_out  output  1  head entry valid.
- PCInc_out  output  16  head PC+2; 16'h0000 when empty.
- Instr_out  output  16  head instruction; NOP_INSTR when empty.
- err_out  output  1  head entry error bit; 0 when empty.

Behaviour:
- Storage: 2 entries of {PCInc, Instr, err}, write pointer wp, read pointer rp (1 bit each, wrap 1→0), count 0..2.
- Reset (rst==0 at edge): count=0, wp=rp=0, entries cleared. Outputs then: Valid_out=0, Instr_out=16'h0800, PCInc_out=0, err_out=0, En=1.
- full = (count==2). En = ~full. En is purely from state; it does not combine with Stall_ID.
- push = ~nop_in & ~full & ~Flush. On push, write the entry at wp and increment wp.
- ready = ~Stall_ID & ~Dmem_Stall. pop = (count!=0) & ready & ~Flush. On pop, increment rp.
- count_next = count + push - pop. Simultaneous push and pop at count 1 keeps count at 1 and advances both pointers.
- At count 2, push is blocked even if pop occurs in the same cycle. Fetch holds its PC because En was 0.
- Flush has top priority over push and pop. It sets count=0 and wp=rp=0, and drops the incoming fetch word. The next cycle shows Valid_out=0 and Instr_out=NOP_INSTR.
- Outputs are combinational from registered head (entry[rp]) gated by count!=0. There are no combinational paths from inputs to outputs except through state; zero-cycle latency is not allowed.
- Latency: an instruction pushed at edge N is visible on the outputs after edge N (decode samples at N+1) when the FIFO was empty.
- err_in is stored per entry. It is not sticky and leaves with its entry.
- Reset has priority over Flush, push and pop.

Optional Feature:
- Macro IFID_BUBBLE_CNT_EN.
- When defined, adds output bubble_cnt [15:0]. It increments by 1 on each cycle where rst==1, ready==1 and count==0 (decode idle for lack of an instruction). It saturates at 16'hFFFF, clears on reset, and does not clear on Flush.
- When not defined, the port and counter are absent and the behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 two cycles with nop_in=0 and Instr_in=16'h1234 → Valid_out=0, Instr_out=16'h0800, En=1, PCInc_out=0.
- Streaming: push 16'hA001/PCInc 0002, then 16'hA002/0004, then 16'hA003/0006 on consecutive cycles with ready=1 → Instr_out shows each one cycle after its push, count stays ≤1, En stays 1.
- Back-pressure: Stall_ID=1 while pushing 3 instructions → after 2 pushes En=0 and the third is not stored. Release the stall → outputs drain in order A001, A002, and En returns to 1 the cycle after the first pop.
- Flush: with 2 entries held and nop_in=0 on the flush cycle, Flush=1 → next cycle Valid_out=0, Instr_out=16'h0800, En=1. The incoming instruction is not stored.
- Bubble and error: nop_in=1 for 3 cycles → Valid_out=0 throughout. Then push Instr 16'hB000 with err_in=1 → err_out=1 only while that entry is head. Dmem_Stall=1 holds it as head.
- Mid-operation reset and counter (IFID_BUBBLE_CNT_EN): with count=2, drive rst=0 → count=0 next cycle. 5 idle ready cycles → bubble_cnt=5. Preload bubble_cnt to 16'hFFFF → it stays at FFFF.
